// File: rtl/heap_arbiter.sv
// heap_arbiter: round-robin front end for a shared array heap.
// Owns heap memory, per-array sizes and the freed-array stack, and serialises
// array/free/push/read/write/size operations from NReq requesters.
// Optional feature macro: HEAP_ARBITER_CLEAR_EN -- zero a freshly allocated
// area (one element per cycle) before acknowledging the array operation.
module heap_arbiter #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 3,
    parameter int NArrays            = 4,
    parameter int NReq               = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req,
    input  logic [3*NReq-1:0]                  op,
    input  logic [MemoryElementWidth*NReq-1:0] array,
    input  logic [MemoryElementWidth*NReq-1:0] index,
    input  logic [MemoryElementWidth*NReq-1:0] wdata,
    output logic [NReq-1:0]                    ack,
    output logic [MemoryElementWidth-1:0]      rdata,
    output logic                               error,
    output logic                               busy
);
    localparam int W     = MemoryElementWidth;
    localparam int DEPTH = NArrays * NArea;
    localparam int HW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // heap index width
    localparam int AW    = $clog2(DEPTH) + 1;                 // non-wrapping address width
    localparam int NW    = $clog2(NArrays + 1);               // allocs / top counters
    localparam int SW    = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int GW    = (NReq > 1) ? $clog2(NReq) : 1;

    localparam logic [2:0] OP_ARRAY = 3'd1;
    localparam logic [2:0] OP_FREE  = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_WRITE = 3'd5;
    localparam logic [2:0] OP_SIZE  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    // latched request
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   r_prio;
    logic [2:0]      r_op;
    logic [W-1:0]    r_arr;
    logic [W-1:0]    r_idx;
    logic [W-1:0]    r_wd;

    // allocation state
    logic [NW-1:0]   r_allocs;
    logic [NW-1:0]   r_top;
    logic [W-1:0]    r_freed [NArrays];
    logic [W-1:0]    r_sizes [NArrays];
    logic [W-1:0]    r_heap  [DEPTH];

    // registered results
    logic [NReq-1:0] r_ack;
    logic [W-1:0]    r_rdata;
    logic            r_error;

`ifdef HEAP_ARBITER_CLEAR_EN
    logic [AW-1:0]   r_clr;
    logic [AW-1:0]   r_cbase;
`endif

    // arbitration / operand select
    logic [2*NReq-1:0] w_req2;
    logic [NReq-1:0]   w_rot;
    logic [GW-1:0]     w_gnt;
    logic [2:0]        w_op;
    logic [W-1:0]      w_arr;
    logic [W-1:0]      w_idx;
    logic [W-1:0]      w_wd;
    logic [NReq-1:0]   w_onehot;

    // execute datapath
    logic [SW-1:0]   w_ai;
    logic [SW-1:0]   w_tm1;
    logic [W-1:0]    w_size;
    logic [W-1:0]    w_new_n;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_addr;
    logic            w_arr_bad;
    logic            w_idx_bad;
    logic            w_err;
    logic [W-1:0]    w_res;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [W-1:0]    w_wdat;

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign error = r_error;
    assign busy  = (r_state != ST_IDLE);

    // Round-robin pick: rotate requests so prio sits at bit 0, take the lowest set bit.
    always_comb begin
        w_req2 = {req, req};
        w_rot  = NReq'(w_req2 >> r_prio);
        w_gnt  = '0;
        for (int k = NReq - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_gnt = (int'(r_prio) + k >= NReq) ? GW'(int'(r_prio) + k - NReq)
                                                   : GW'(int'(r_prio) + k);
            end
        end
    end

    // Operand mux for the winning requester, and the one-hot ack for the latched one.
    always_comb begin
        w_op     = '0;
        w_arr    = '0;
        w_idx    = '0;
        w_wd     = '0;
        w_onehot = '0;
        for (int r = 0; r < NReq; r++) begin
            if (w_gnt == GW'(r)) begin
                w_op  = op[3*r +: 3];
                w_arr = array[W*r +: W];
                w_idx = index[W*r +: W];
                w_wd  = wdata[W*r +: W];
            end
            w_onehot[r] = (r_gnt == GW'(r));
        end
    end

    // Decode the latched operation: error checks, result value and heap address.
    always_comb begin
        w_ai      = r_arr[SW-1:0];
        w_tm1     = r_top[SW-1:0] - SW'(1);
        w_size    = r_sizes[w_ai];
        w_new_n   = (r_top != '0) ? r_freed[w_tm1] : W'(r_allocs);
        w_base    = AW'(w_ai) * AW'(NArea);
        w_addr    = (r_op == OP_PUSH) ? (w_base + AW'(w_size)) : (w_base + AW'(r_idx));
        w_arr_bad = (r_arr >= W'(NArrays));
        w_idx_bad = (r_idx >= W'(NArea));
        w_err     = 1'b0;
        w_res     = '0;
        case (r_op)
            OP_ARRAY: begin
                w_err = (r_top == '0) && (r_allocs == NW'(NArrays));
                w_res = w_new_n;
            end
            OP_FREE:  w_err = (r_arr >= W'(r_allocs)) || (r_top == NW'(NArrays));
            OP_PUSH: begin
                w_err = w_arr_bad || (w_size == W'(NArea));
                w_res = w_size + W'(1);
            end
            OP_READ: begin
                w_err = w_arr_bad || w_idx_bad;
                w_res = r_heap[w_addr[HW-1:0]];
            end
            OP_WRITE: w_err = w_arr_bad || w_idx_bad;
            OP_SIZE: begin
                w_err = w_arr_bad;
                w_res = w_size;
            end
            default:  w_err = 1'b1;
        endcase
        if (w_err) w_res = '0;
    end

    // Heap write port: push/write in EXEC, zero fill in CLEAR; never past the heap end.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_addr;
        w_wdat  = r_wd;
        if (r_state == ST_EXEC && !w_err && (r_op == OP_PUSH || r_op == OP_WRITE)) begin
            w_we = 1'b1;
        end
`ifdef HEAP_ARBITER_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_cbase + r_clr;
            w_wdat  = '0;
        end
`endif
        if (w_waddr >= AW'(DEPTH)) w_we = 1'b0;
    end

    // Heap storage, deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_we) r_heap[w_waddr[HW-1:0]] <= w_wdat;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|req) w_next = ST_EXEC;
            ST_EXEC: begin
                w_next = ST_ACK;
`ifdef HEAP_ARBITER_CLEAR_EN
                if (r_op == OP_ARRAY && !w_err) w_next = ST_CLEAR;
`endif
            end
`ifdef HEAP_ARBITER_CLEAR_EN
            ST_CLEAR: if (r_clr == AW'(NArea - 1)) w_next = ST_ACK;
`endif
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant latch, allocation bookkeeping and registered results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gnt    <= '0;
            r_prio   <= '0;
            r_op     <= '0;
            r_arr    <= '0;
            r_idx    <= '0;
            r_wd     <= '0;
            r_allocs <= '0;
            r_top    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                r_freed[i] <= '0;
                r_sizes[i] <= '0;
            end
`ifdef HEAP_ARBITER_CLEAR_EN
            r_clr    <= '0;
            r_cbase  <= '0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt <= w_gnt;
                        r_op  <= w_op;
                        r_arr <= w_arr;
                        r_idx <= w_idx;
                        r_wd  <= w_wd;
                    end
                end
                ST_EXEC: begin
                    r_rdata <= w_res;
                    r_error <= w_err;
                    if (!w_err) begin
                        case (r_op)
                            OP_ARRAY: begin
                                if (r_top != '0) r_top    <= r_top - NW'(1);
                                else             r_allocs <= r_allocs + NW'(1);
                                r_sizes[w_new_n[SW-1:0]] <= '0;
`ifdef HEAP_ARBITER_CLEAR_EN
                                r_cbase <= AW'(w_new_n[SW-1:0]) * AW'(NArea);
                                r_clr   <= '0;
`endif
                            end
                            OP_FREE: begin
                                r_freed[r_top[SW-1:0]] <= r_arr;
                                r_top                  <= r_top + NW'(1);
                            end
                            OP_PUSH:  r_sizes[w_ai] <= w_size + W'(1);
                            OP_WRITE: if (r_idx >= w_size) r_sizes[w_ai] <= r_idx + W'(1);
                            default: ;
                        endcase
                    end
                end
`ifdef HEAP_ARBITER_CLEAR_EN
                ST_CLEAR: r_clr <= r_clr + AW'(1);
`endif
                ST_ACK: begin
                    r_prio  <= (r_gnt == GW'(NReq - 1)) ? '0 : r_gnt + GW'(1);
                    r_rdata <= '0;
                    r_error <= 1'b0;
                end
                default: ;
            endcase
            if (w_next == ST_ACK && r_state != ST_ACK) r_ack <= w_onehot;
        end
    end

endmodule

// File: tb/tb_heap_arbiter.sv
// Bench for heap_arbiter: directed scenarios with literal expectations plus
// randomized two-requester traffic checked every cycle against a queue/array model.
module tb_heap_arbiter;
    localparam int W   = 12;
    localparam int NA  = 3;
    localparam int NAR = 4;
    localparam int NR  = 2;
`ifdef HEAP_ARBITER_CLEAR_EN
    localparam bit CLR = 1'b1;
    localparam int ALAT = 3 + NA;
`else
    localparam bit CLR = 1'b0;
    localparam int ALAT = 3;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0]   req;
    logic [3*NR-1:0] op;
    logic [W*NR-1:0] array, index, wdata;
    logic [NR-1:0]   ack;
    logic [W-1:0]    rdata;
    logic            error, busy;

    logic            t_req [NR];
    logic [2:0]      t_op  [NR];
    logic [W-1:0]    t_arr [NR];
    logic [W-1:0]    t_idx [NR];
    logic [W-1:0]    t_wd  [NR];

    for (genvar r = 0; r < NR; r++) begin : g_map
        assign req[r]         = t_req[r];
        assign op[3*r +: 3]   = t_op[r];
        assign array[W*r +: W] = t_arr[r];
        assign index[W*r +: W] = t_idx[r];
        assign wdata[W*r +: W] = t_wd[r];
    end

    heap_arbiter #(.MemoryElementWidth(W), .NArea(NA), .NArrays(NAR), .NReq(NR)) dut (
        .clock(clock), .reset(reset), .req(req), .op(op), .array(array),
        .index(index), .wdata(wdata), .ack(ack), .rdata(rdata), .error(error), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_sizes [NAR];
    int m_heap  [NAR][NA];
    bit m_known [NAR][NA];
    int m_freed [$];
    int m_allocs, m_prio;
    bit pend;
    int m_g, m_gcyc, m_ackc, m_rd;
    bit m_e, m_rdok;
    int cyc = 0;
    int ack_log [$];
    int ea;

    task automatic m_reset();
        for (int a = 0; a < NAR; a++) m_sizes[a] = 0;
        m_freed.delete();
        m_allocs = 0;
        m_prio   = 0;
        pend     = 1'b0;
    endtask

    // Apply one operation to the model; clr reports a successful allocation.
    task automatic m_apply(input int o, input int a, input int i, input int d,
                           output int rd, output bit e, output bit rdok, output bit clr);
        int n;
        e = 0; rd = 0; rdok = 1; clr = 0; n = 0;
        case (o)
            1: begin
                if (m_freed.size() > 0) n = m_freed.pop_back();
                else if (m_allocs < NAR) begin n = m_allocs; m_allocs++; end
                else e = 1;
                if (!e) begin
                    m_sizes[n] = 0;
                    rd = n;
                    clr = CLR;
                    if (CLR) for (int k = 0; k < NA; k++) begin m_heap[n][k] = 0; m_known[n][k] = 1; end
                end
            end
            2: if (a >= m_allocs || m_freed.size() == NAR) e = 1; else m_freed.push_back(a);
            3: if (a >= NAR || m_sizes[a] == NA) e = 1;
               else begin
                   m_heap[a][m_sizes[a]] = d; m_known[a][m_sizes[a]] = 1;
                   m_sizes[a]++; rd = m_sizes[a];
               end
            4: if (a >= NAR || i >= NA) e = 1;
               else begin rd = m_heap[a][i]; rdok = m_known[a][i]; end
            5: if (a >= NAR || i >= NA) e = 1;
               else begin
                   m_heap[a][i] = d; m_known[a][i] = 1; rdok = 0;
                   if (i + 1 > m_sizes[a]) m_sizes[a] = i + 1;
               end
            6: if (a >= NAR) e = 1; else rd = m_sizes[a];
            default: e = 1;
        endcase
    endtask

    // Per-cycle compare: outputs sampled on the falling edge against the model.
    always @(negedge clock) begin
        bit clr;
        if (reset) begin
            chk("rst_ack", int'(ack), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rdata", int'(rdata), 0);
            chk("rst_error", int'(error), 0);
            m_reset();
        end else begin
            ea = (pend && cyc == m_ackc) ? (1 << m_g) : 0;
            chk("ack", int'(ack), ea);
            chk("busy", int'(busy), (pend && cyc > m_gcyc) ? 1 : 0);
            if (pend && cyc == m_ackc) begin
                ack_log.push_back(m_g);
                chk("error", int'(error), int'(m_e));
                if (!m_e && m_rdok) chk("rdata", int'(rdata), m_rd);
                pend   = 1'b0;
                m_prio = (m_g + 1) % NR;
            end else if (!pend && req != '0) begin
                for (int k = NR - 1; k >= 0; k--)
                    if (req[(m_prio + k) % NR]) m_g = (m_prio + k) % NR;
                m_apply(int'(t_op[m_g]), int'(t_arr[m_g]), int'(t_idx[m_g]), int'(t_wd[m_g]),
                        m_rd, m_e, m_rdok, clr);
                pend   = 1'b1;
                m_gcyc = cyc;
                m_ackc = cyc + 2 + (clr ? NA : 0);
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int r, input int o, input int a, input int i, input int d,
                         input bit hold, output int rd, output int e, output int lat);
        bit done;
        t_op[r] = 3'(o); t_arr[r] = W'(a); t_idx[r] = W'(i); t_wd[r] = W'(d);
        t_req[r] = 1'b1;
        lat = 0; rd = -1; e = -1; done = 0;
        while (!done && lat < 60) begin
            @(negedge clock);
            lat++;
            if (ack[r]) begin rd = int'(rdata); e = int'(error); done = 1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout requester %0d actual no ack required ack", r);
        end
        @(posedge clock); #1;
        if (!hold) t_req[r] = 1'b0;
    endtask

    task automatic op_chk(input string nm, input int o, input int a, input int i, input int d,
                          input int exp_rd, input int exp_e, input int exp_lat);
        int rd, e, lat;
        issue(0, o, a, i, d, 1'b0, rd, e, lat);
        chk({nm, "_err"}, e, exp_e);
        if (exp_rd >= 0)  chk({nm, "_rd"}, rd, exp_rd);
        if (exp_lat > 0)  chk({nm, "_lat"}, lat, exp_lat);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        for (int r = 0; r < NR; r++) t_req[r] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic rand_requester(input int r);
        int rd, e, lat, o;
        bit hold;
        hold = 0;
        repeat (60) begin
            if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            o = $urandom_range(0, 9);
            if (o > 7) o = (o == 8) ? 1 : 3;
            hold = 1'($urandom_range(0, 1));
            issue(r, o, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 4095),
                  hold, rd, e, lat);
        end
        t_req[r] = 1'b0;
    endtask

    initial begin
        int rd0, e0, l0, rd1, e1, l1;
        for (int r = 0; r < NR; r++) begin
            t_req[r] = 0; t_op[r] = 0; t_arr[r] = 0; t_idx[r] = 0; t_wd[r] = 0;
        end
        do_reset();

        // single requester basic flow
        op_chk("t1_array", 1, 0, 0, 0, 0, 0, ALAT);
        op_chk("t1_push1", 3, 0, 0, 1, 1, 0, 3);
        op_chk("t1_push2", 3, 0, 0, 2, 2, 0, 3);
        op_chk("t1_size",  6, 0, 0, 0, 2, 0, 3);
        op_chk("t1_read0", 4, 0, 0, 0, 1, 0, 3);
        op_chk("t1_read1", 4, 0, 1, 0, 2, 0, 3);

        // allocation exhaustion and reuse
        do_reset();
        for (int n = 0; n < NAR; n++) op_chk("t2_alloc", 1, 0, 0, 0, n, 0, ALAT);
        op_chk("t2_exhaust", 1, 0, 0, 0, -1, 1, 3);
        op_chk("t2_free2",   2, 2, 0, 0, 0, 0, 3);
        op_chk("t2_reuse",   1, 0, 0, 0, 2, 0, ALAT);
        op_chk("t2_free5",   2, 5, 0, 0, -1, 1, 3);

        // size limits
        do_reset();
        op_chk("t3_array", 1, 0, 0, 0, 0, 0, ALAT);
        for (int k = 1; k <= NA; k++) op_chk("t3_push", 3, 0, 0, 10 + k, k, 0, 3);
        op_chk("t3_push_full", 3, 0, 0, 99, -1, 1, 3);
        op_chk("t3_size",      6, 0, 0, 0, 3, 0, 3);
        op_chk("t3_wr_idx3",   5, 0, 3, 5, -1, 1, 3);
        op_chk("t3_array1",    1, 0, 0, 0, 1, 0, ALAT);
        op_chk("t3_wr_idx1",   5, 1, 1, 42, -1, 0, 3);
        op_chk("t3_size1",     6, 1, 0, 0, 2, 0, 3);

        // continuous requests from both: strict alternation, requester 0 first
        do_reset();
        ack_log.delete();
        fork
            begin issue(0, 6, 0, 0, 0, 1'b1, rd0, e0, l0); issue(0, 6, 0, 0, 0, 1'b0, rd0, e0, l0); end
            begin issue(1, 6, 0, 0, 0, 1'b1, rd1, e1, l1); issue(1, 6, 0, 0, 0, 1'b0, rd1, e1, l1); end
        join
        chk("rr_count", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("rr_0", ack_log[0], 0);
            chk("rr_1", ack_log[1], 1);
            chk("rr_2", ack_log[2], 0);
            chk("rr_3", ack_log[3], 1);
        end

        // reset during the EXEC cycle of a push
        do_reset();
        op_chk("t5_array", 1, 0, 0, 0, 0, 0, ALAT);
        t_op[0] = 3'd3; t_arr[0] = '0; t_wd[0] = W'(9); t_req[0] = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        t_req[0] = 1'b0;
        #1;
        chk("t5_busy_now", int'(busy), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        op_chk("t5_array2", 1, 0, 0, 0, 0, 0, ALAT);
        op_chk("t5_size",   6, 0, 0, 0, 0, 0, 3);

        // reuse of a freed area: cleared or stale
        do_reset();
        op_chk("t6_array", 1, 0, 0, 0, 0, 0, ALAT);
        op_chk("t6_push7", 3, 0, 0, 7, 1, 0, 3);
        op_chk("t6_free0", 2, 0, 0, 0, 0, 0, 3);
        op_chk("t6_realloc", 1, 0, 0, 0, 0, 0, ALAT);
        op_chk("t6_read0", 4, 0, 0, 0, CLR ? 0 : 7, 0, 3);

        // randomized two-requester traffic
        do_reset();
        fork
            rand_requester(0);
            rand_requester(1);
        join
        repeat (4 + NA) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual still running required finished");
        $fatal(1, "watchdog");
    end

endmodule
